// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus timer target: register offsets and bit positions
// inside the CTRL and STAT registers.
package bus_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STAT     = 3'd1;
  localparam logic [2:0] REG_LATCH_LO = 3'd2;
  localparam logic [2:0] REG_LATCH_HI = 3'd3;
  localparam logic [2:0] REG_COUNT_LO = 3'd4;
  localparam logic [2:0] REG_COUNT_HI = 3'd5;
  localparam logic [2:0] REG_SCRATCH  = 3'd6;
  localparam logic [2:0] REG_ID       = 3'd7;

  localparam int EN_BIT   = 0;
  localparam int CONT_BIT = 1;
  localparam int IE_BIT   = 2;
  localparam int UF_BIT   = 0;

endpackage

// File: rtl/bus_timer_core.sv
// Timer datapath: 16-bit down-counter with reload, underflow flag and, when
// TIMER_PRESCALE_EN is defined, an 8-bit prescaler gating the count ticks.
module bus_timer_core
  import bus_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_en,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [15:0] reload_val,
  input  logic        uf_clr,
  input  logic        cont,
`ifdef TIMER_PRESCALE_EN
  input  logic [7:0]  presc,
  input  logic        presc_clr,
`endif
  output logic [15:0] count,
  output logic        uf,
  output logic        uf_set,
  output logic        en_clr
);

  logic tick;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] presc_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (presc_clr) begin
      presc_cnt <= '0;
    end else if (tick_en) begin
      presc_cnt <= (presc_cnt == presc) ? 8'd0 : presc_cnt + 8'd1;
    end
  end

  assign tick = tick_en && (presc_cnt == presc);
`else
  assign tick = tick_en;
`endif

  assign uf_set = tick && (count == 16'd0);
  assign en_clr = uf_set && !cont;

  // A load strobe overrides both the decrement and the auto-reload.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick) begin
      if (count != 16'd0) count <= count - 16'd1;
      else if (cont)      count <= reload_val;
    end
  end

  // Setting beats clearing so an underflow is never lost to a coincident W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       uf <= 1'b0;
    else if (uf_set) uf <= 1'b1;
    else if (uf_clr) uf <= 1'b0;
  end

endmodule

// File: rtl/bus_timer_target.sv
// Bus responder for the timer: 8-byte window decode, register file and
// registered read data. Optional macro: TIMER_PRESCALE_EN (register 7 = PRESC).
module bus_timer_target
  import bus_timer_pkg::*;
#(
  parameter logic [18:0] BASE            = 19'h0B800,
  parameter logic [7:0]  ID_VALUE        = 8'hA5,
  parameter bit          RELOAD_ON_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] AB,
  input  logic [7:0]  DI,
  input  logic        WE,
  output logic [7:0]  DO,
  output logic        DO_en,
  output logic        IRQ
);

  logic        hit, rd, wr;
  logic [2:0]  reg_sel;
  logic [2:0]  ctrl;
  logic [7:0]  latch_lo, latch_hi, shadow, scratch, rdata;
  logic [15:0] count;
  logic        uf, uf_set, en_clr, load, uf_clr;
  logic        wr_ctrl, wr_stat, wr_lo, wr_hi, wr_scratch;

  assign hit     = (AB[18:3] == BASE[18:3]);
  assign reg_sel = AB[2:0];
  assign wr      = hit && WE;
  assign rd      = hit && !WE;

  assign wr_ctrl    = wr && (reg_sel == REG_CTRL);
  assign wr_stat    = wr && (reg_sel == REG_STAT);
  assign wr_lo      = wr && (reg_sel == REG_LATCH_LO);
  assign wr_hi      = wr && (reg_sel == REG_LATCH_HI);
  assign wr_scratch = wr && (reg_sel == REG_SCRATCH);

  assign load   = wr_hi && RELOAD_ON_START;
  assign uf_clr = (wr_stat && DI[UF_BIT]) || load;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] presc;
  logic       presc_clr;
  assign presc_clr = (wr_ctrl && DI[EN_BIT] && !ctrl[EN_BIT]) || wr_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              presc <= '0;
    else if (wr && (reg_sel == REG_ID))     presc <= DI;
  end
`endif

  bus_timer_core u_core (
    .clk        (clk),
    .reset      (reset),
    .tick_en    (ctrl[EN_BIT]),
    .load       (load),
    .load_val   ({DI, latch_lo}),
    .reload_val ({latch_hi, latch_lo}),
    .uf_clr     (uf_clr),
    .cont       (ctrl[CONT_BIT]),
`ifdef TIMER_PRESCALE_EN
    .presc      (presc),
    .presc_clr  (presc_clr),
`endif
    .count      (count),
    .uf         (uf),
    .uf_set     (uf_set),
    .en_clr     (en_clr)
  );

  // The later en_clr assignment overrides a CTRL write that keeps EN set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else begin
      if (wr_ctrl) ctrl <= DI[2:0];
      if (en_clr)  ctrl[EN_BIT] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_lo <= 8'hFF;
      latch_hi <= 8'hFF;
      scratch  <= '0;
      shadow   <= '0;
    end else begin
      if (wr_lo)      latch_lo <= DI;
      if (wr_hi)      latch_hi <= DI;
      if (wr_scratch) scratch  <= DI;
      if (rd && (reg_sel == REG_COUNT_LO)) shadow <= count[15:8];
    end
  end

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:     rdata = {5'b0, ctrl};
      REG_STAT:     rdata = {7'b0, uf};
      REG_LATCH_LO: rdata = latch_lo;
      REG_LATCH_HI: rdata = latch_hi;
      REG_COUNT_LO: rdata = count[7:0];
      REG_COUNT_HI: rdata = shadow;
      REG_SCRATCH:  rdata = scratch;
`ifdef TIMER_PRESCALE_EN
      REG_ID:       rdata = presc;
`else
      REG_ID:       rdata = ID_VALUE;
`endif
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DO    <= '0;
      DO_en <= 1'b0;
    end else begin
      DO    <= rd ? rdata : 8'h00;
      DO_en <= rd;
    end
  end

  assign IRQ = uf && ctrl[IE_BIT];

endmodule

// File: tb/tb_bus_timer_target.sv
// Directed, table-driven bench for bus_timer_target: one bus cycle per vector,
// outputs compared on the falling edge after the active edge.
module tb_bus_timer_target;

  localparam logic [18:0] BASE = 19'h0B800;
`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] ID_EXP = 8'h00;
`else
  localparam logic [7:0] ID_EXP = 8'hA5;
`endif

  typedef struct {
    logic        we;
    logic [18:0] ab;
    logic [7:0]  di;
    logic [7:0]  exp_do;
    logic        exp_en;
    logic        exp_irq;
  } vec_t;

  logic        clk, reset, WE;
  logic [18:0] AB;
  logic [7:0]  DI, DO;
  logic        DO_en, IRQ;

  int n_total = 0;
  int n_pass  = 0;

  bus_timer_target dut (
    .clk   (clk),
    .reset (reset),
    .AB    (AB),
    .DI    (DI),
    .WE    (WE),
    .DO    (DO),
    .DO_en (DO_en),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t rd(input logic [2:0] r, input logic [7:0] d, input logic irq);
    vec_t v;
    v.we = 1'b0; v.ab = BASE + {16'b0, r}; v.di = 8'h00;
    v.exp_do = d; v.exp_en = 1'b1; v.exp_irq = irq;
    return v;
  endfunction

  function automatic vec_t wr(input logic [2:0] r, input logic [7:0] d, input logic irq);
    vec_t v;
    v.we = 1'b1; v.ab = BASE + {16'b0, r}; v.di = d;
    v.exp_do = 8'h00; v.exp_en = 1'b0; v.exp_irq = irq;
    return v;
  endfunction

  function automatic vec_t idle(input logic irq);
    vec_t v;
    v.we = 1'b0; v.ab = 19'h00000; v.di = 8'h00;
    v.exp_do = 8'h00; v.exp_en = 1'b0; v.exp_irq = irq;
    return v;
  endfunction

  // Drive one bus cycle from a falling edge, compare on the next falling edge.
  task automatic step(input vec_t v, input string tag);
    AB = v.ab; DI = v.di; WE = v.we;
    @(negedge clk);
    check({tag, "/DO"},    {8'h00, DO},    {8'h00, v.exp_do});
    check({tag, "/DO_en"}, {15'h0, DO_en}, {15'h0, v.exp_en});
    check({tag, "/IRQ"},   {15'h0, IRQ},   {15'h0, v.exp_irq});
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    reset = 1'b1; AB = '0; DI = '0; WE = 1'b0;
    #12;
    check("reset/DO", {8'h00, DO}, 16'h0000);
    check("reset/DO_en", {15'h0, DO_en}, 16'h0000);
    check("reset/IRQ", {15'h0, IRQ}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Reset values, window decode, scratch.
    tbl.push_back(rd(3'd7, ID_EXP, 1'b0));
    v = idle(1'b0); v.ab = 19'h0B808; tbl.push_back(v);
    tbl.push_back(rd(3'd0, 8'h00, 1'b0));
    tbl.push_back(rd(3'd2, 8'hFF, 1'b0));
    tbl.push_back(rd(3'd3, 8'hFF, 1'b0));
    tbl.push_back(rd(3'd4, 8'h00, 1'b0));
    tbl.push_back(wr(3'd6, 8'h5A, 1'b0));
    tbl.push_back(rd(3'd6, 8'h5A, 1'b0));
    // Continuous mode, latch 3: count 3,2,1,0 then reload, UF every 4 clocks.
    tbl.push_back(wr(3'd2, 8'h03, 1'b0));
    tbl.push_back(wr(3'd3, 8'h00, 1'b0));
    tbl.push_back(rd(3'd2, 8'h03, 1'b0));
    tbl.push_back(wr(3'd0, 8'h07, 1'b0));
    tbl.push_back(rd(3'd4, 8'h03, 1'b0));
    tbl.push_back(rd(3'd4, 8'h02, 1'b0));
    tbl.push_back(rd(3'd4, 8'h01, 1'b0));
    tbl.push_back(rd(3'd4, 8'h00, 1'b1));
    tbl.push_back(rd(3'd4, 8'h03, 1'b1));
    tbl.push_back(rd(3'd1, 8'h01, 1'b1));
    tbl.push_back(wr(3'd1, 8'h01, 1'b0));
    tbl.push_back(idle(1'b1));
    tbl.push_back(idle(1'b1));
    tbl.push_back(wr(3'd1, 8'h01, 1'b0));
    tbl.push_back(idle(1'b0));
    tbl.push_back(wr(3'd1, 8'h01, 1'b1));   // W1C in the underflow cycle
    tbl.push_back(wr(3'd1, 8'h01, 1'b0));
    // One-shot, latch 2.
    tbl.push_back(wr(3'd0, 8'h00, 1'b0));
    tbl.push_back(wr(3'd2, 8'h02, 1'b0));
    tbl.push_back(wr(3'd3, 8'h00, 1'b0));
    tbl.push_back(wr(3'd0, 8'h05, 1'b0));
    tbl.push_back(idle(1'b0));
    tbl.push_back(idle(1'b0));
    tbl.push_back(rd(3'd0, 8'h05, 1'b1));
    tbl.push_back(rd(3'd0, 8'h04, 1'b1));
    tbl.push_back(rd(3'd4, 8'h00, 1'b1));
    tbl.push_back(wr(3'd1, 8'h01, 1'b0));
    tbl.push_back(idle(1'b0));
    tbl.push_back(rd(3'd1, 8'h00, 1'b0));
    // CTRL write clearing EN in the underflow cycle.
    tbl.push_back(wr(3'd2, 8'h01, 1'b0));
    tbl.push_back(wr(3'd3, 8'h00, 1'b0));
    tbl.push_back(wr(3'd0, 8'h07, 1'b0));
    tbl.push_back(idle(1'b0));
    tbl.push_back(wr(3'd0, 8'h04, 1'b1));
    tbl.push_back(rd(3'd0, 8'h04, 1'b1));
    tbl.push_back(rd(3'd4, 8'h01, 1'b1));
    tbl.push_back(wr(3'd1, 8'h01, 1'b0));
    // LATCH_HI write in the underflow cycle: load wins, UF still set.
    tbl.push_back(wr(3'd2, 8'h00, 1'b0));
    tbl.push_back(wr(3'd3, 8'h00, 1'b0));
    tbl.push_back(wr(3'd0, 8'h07, 1'b0));
    tbl.push_back(wr(3'd3, 8'h01, 1'b1));
    tbl.push_back(rd(3'd4, 8'h00, 1'b1));
    tbl.push_back(rd(3'd5, 8'h01, 1'b1));
    tbl.push_back(wr(3'd0, 8'h00, 1'b0));
    tbl.push_back(wr(3'd1, 8'h01, 1'b0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Atomic 16-bit read across the 0x1200 -> 0x11FF rollover.
    step(wr(3'd2, 8'h34, 1'b0), "atom_lo");
    step(wr(3'd3, 8'h12, 1'b0), "atom_hi");
    step(wr(3'd0, 8'h01, 1'b0), "atom_en");
    for (int i = 0; i < 52; i++) begin
      AB = 19'h00000; WE = 1'b0;
      @(negedge clk);
    end
    step(rd(3'd4, 8'h00, 1'b0), "atom_rd_lo");
    step(rd(3'd5, 8'h12, 1'b0), "atom_rd_hi");
    step(rd(3'd4, 8'hFE, 1'b0), "atom_rd_lo2");
    step(wr(3'd0, 8'h00, 1'b0), "atom_dis");

    // Asynchronous reset while counting with IRQ and DO_en high.
    step(wr(3'd2, 8'h00, 1'b0), "rst_lo");
    step(wr(3'd3, 8'h00, 1'b0), "rst_hi");
    step(wr(3'd0, 8'h07, 1'b0), "rst_en");
    step(idle(1'b1), "rst_uf");
    step(rd(3'd7, ID_EXP, 1'b1), "rst_rd");
    #1 reset = 1'b1;
    #1;
    check("async_rst/DO", {8'h00, DO}, 16'h0000);
    check("async_rst/DO_en", {15'h0, DO_en}, 16'h0000);
    check("async_rst/IRQ", {15'h0, IRQ}, 16'h0000);
    #1 reset = 1'b0;
    @(negedge clk);
    step(idle(1'b0), "post_idle");
    step(rd(3'd0, 8'h00, 1'b0), "post_ctrl");
    step(rd(3'd4, 8'h00, 1'b0), "post_count");
    step(rd(3'd3, 8'hFF, 1'b0), "post_latch");
    step(rd(3'd1, 8'h00, 1'b0), "post_stat");

`ifdef TIMER_PRESCALE_EN
    // PRESC = 1, latch = 1, continuous: UF every 4 clocks.
    step(wr(3'd7, 8'h01, 1'b0), "ps_presc");
    step(wr(3'd2, 8'h01, 1'b0), "ps_lo");
    step(wr(3'd3, 8'h00, 1'b0), "ps_hi");
    step(wr(3'd0, 8'h07, 1'b0), "ps_en");
    step(idle(1'b0), "ps_a");
    step(idle(1'b0), "ps_b");
    step(idle(1'b0), "ps_c");
    step(idle(1'b1), "ps_d");
    step(wr(3'd1, 8'h01, 1'b0), "ps_w1c");
    step(idle(1'b0), "ps_f");
    step(idle(1'b0), "ps_g");
    step(idle(1'b1), "ps_h");
    step(rd(3'd7, 8'h01, 1'b1), "ps_rd");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
